// File: rtl/shift_exec_stage.sv
// Two-stage MIPS shift execute pipeline (sll/srl/sra/sllv/srlv/srav) with valid/ready handshake.
// Optional completion counter port op_count enabled by defining SHIFT_STATS_EN.

module barrel_shifter (
    input  logic [31:0] data,
    input  logic [4:0]  amount,
    input  logic        right,
    input  logic        arith,
    output logic [31:0] result
);
    logic [5:0][31:0] stage;
    logic             fill;

    assign fill     = arith & data[31];
    assign stage[0] = data;

    // Log-depth network: level gi shifts by 2**gi when amount[gi] is set.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_level
            localparam int SH = 1 << gi;
            logic [31:0] shifted;

            always_comb begin
                if (right) begin
                    shifted = {{SH{fill}}, stage[gi][31:SH]};
                end else begin
                    shifted = {stage[gi][31-SH:0], {SH{1'b0}}};
                end
            end

            assign stage[gi+1] = amount[gi] ? shifted : stage[gi];
        end
    endgenerate

    assign result = stage[5];
endmodule

module shift_exec_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_funct,
    input  logic [4:0]  in_shamt,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_illegal
`ifdef SHIFT_STATS_EN
    ,
    output logic [15:0] op_count
`endif
);
    logic        a_valid_reg;
    logic        a_right_reg;
    logic        a_arith_reg;
    logic        a_illegal_reg;
    logic [4:0]  a_amt_reg;
    logic [31:0] a_rt_reg;

    logic        b_valid_reg;
    logic        b_illegal_reg;
    logic [31:0] b_result_reg;

    logic        a_advance;
    logic        b_advance;
    logic        dec_right;
    logic        dec_arith;
    logic        dec_variable;
    logic        dec_illegal;
    logic [4:0]  dec_amt;
    logic [31:0] shift_result;
    logic        unused_rs;

    assign unused_rs = ^in_rs[31:5];

    always_comb begin
        dec_right    = 1'b0;
        dec_arith    = 1'b0;
        dec_variable = 1'b0;
        dec_illegal  = 1'b0;
        case (in_funct)
            6'b000000: ;
            6'b000010: dec_right = 1'b1;
            6'b000011: begin dec_right = 1'b1; dec_arith = 1'b1; end
            6'b000100: dec_variable = 1'b1;
            6'b000110: begin dec_right = 1'b1; dec_variable = 1'b1; end
            6'b000111: begin dec_right = 1'b1; dec_arith = 1'b1; dec_variable = 1'b1; end
            default:   dec_illegal = 1'b1;
        endcase
    end

    assign dec_amt = dec_variable ? in_rs[4:0] : in_shamt;

    // Each stage may refill in the same cycle its occupant moves on.
    assign b_advance = !b_valid_reg || out_ready;
    assign a_advance = !a_valid_reg || b_advance;
    assign in_ready  = a_advance;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_reg   <= 1'b0;
            a_right_reg   <= 1'b0;
            a_arith_reg   <= 1'b0;
            a_illegal_reg <= 1'b0;
            a_amt_reg     <= 5'd0;
            a_rt_reg      <= 32'd0;
        end else if (a_advance) begin
            a_valid_reg <= in_valid;
            if (in_valid) begin
                a_right_reg   <= dec_right;
                a_arith_reg   <= dec_arith;
                a_illegal_reg <= dec_illegal;
                a_amt_reg     <= dec_amt;
                a_rt_reg      <= in_rt;
            end
        end
    end

    barrel_shifter u_shifter (
        .data   (a_rt_reg),
        .amount (a_amt_reg),
        .right  (a_right_reg),
        .arith  (a_arith_reg),
        .result (shift_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            b_valid_reg   <= 1'b0;
            b_illegal_reg <= 1'b0;
            b_result_reg  <= 32'd0;
        end else if (b_advance) begin
            b_valid_reg <= a_valid_reg;
            if (a_valid_reg) begin
                b_illegal_reg <= a_illegal_reg;
                b_result_reg  <= a_illegal_reg ? 32'd0 : shift_result;
            end
        end
    end

    assign out_valid   = b_valid_reg;
    assign out_result  = b_result_reg;
    assign out_illegal = b_illegal_reg;

`ifdef SHIFT_STATS_EN
    logic [15:0] op_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_count_reg <= 16'd0;
        end else if (b_valid_reg && out_ready && !b_illegal_reg) begin
            op_count_reg <= op_count_reg + 16'd1;
        end
    end

    assign op_count = op_count_reg;
`endif
endmodule
